mult_switch_bank: RTL and testbench
===================================

# mult_switch_bank

Parametrised multiplier switch holding a bank of `DEPTH` selectable stationary operands. Each accepted streaming beat is multiplied by the selected stationary entry in a `PIPE`-deep pipeline. Products are emitted either per beat or accumulated over a run and emitted once at the run's last beat. It sits in the same distribution-tree leaf position as the single-entry multiplier switch, and it adds output backpressure, signed integer arithmetic, error flagging and flush.

## Interface
Parameters:
- `DATA_W`, 16: operand width, two's complement.
- `DEPTH`, 4: number of stationary buffer entries.
- `SEL_W`, 2: entry select width; must satisfy 2^SEL_W >= DEPTH.
- `PIPE`, 2: input-accept to output latency in cycles; must be >= 1.
- `GUARD`, 4: accumulator guard bits.
- Derived: `ACC_W` = 2*DATA_W + GUARD.

Ports:
- `CLK` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `i_valid` input 1: input beat valid.
- `i_ready` output 1: input beat accepted when `i_valid & i_ready`.
- `i_data` input DATA_W: stationary value or streaming operand.
- `i_stationary` input 1: 1 = write `i_data` into entry `i_sel`; 0 = streaming beat.
- `i_sel` input SEL_W: stationary entry index, used for both writes and streaming.
- `i_accum` input 1: streaming beat belongs to an accumulation run.
- `i_last` input 1: final beat of an accumulation run; ignored when `i_accum` = 0.
- `i_flush` input 1: single-cycle pulse; invalidates all entries and clears the accumulator.
- `o_valid` output 1: result valid.
- `o_ready` input 1: downstream accepts the result when `o_valid & o_ready`.
- `o_data` output ACC_W: signed result.
- `o_err` output 1: sticky; set when a streaming beat targets an invalid entry.

## Operation
- Reset (asynchronous assert, synchronous release):
  - All buffer entries = 0 and all entry-valid bits = 0.
  - All pipeline valids = 0, accumulator = 0.
  - `o_valid` = 0, `o_data` = 0, `o_err` = 0.
  - `i_ready` = 1.
- Stall: `stall = o_valid & ~o_ready`. `i_ready = ~stall`. While stalled, every pipeline stage, the accumulator and `o_data` hold.
- Stationary write (accepted, `i_stationary` = 1):
  - `buf[i_sel] <= i_data` and `valid[i_sel] <= 1`.
  - No pipeline entry is created.
  - `i_sel >= DEPTH` is ignored.
- Streaming beat (accepted, `i_stationary` = 0):
  - If `valid[i_sel]`: the signed product `i_data * buf[i_sel]` (2*DATA_W, sign-extended to ACC_W) enters the pipeline with its `accum` and `last` tags.
  - Otherwise the beat is dropped and `o_err <= 1`.
  - The operand is read from the buffer at acceptance. A write to the same entry accepted on the following cycle does not affect a beat already in flight.
- Final stage (product leaving stage PIPE-1):
  - `accum` = 0: `o_data <= prod`, `o_valid <= 1`. The accumulator is untouched.
  - `accum` = 1, `last` = 0: `acc <= acc + prod`; no output slot is produced.
  - `accum` = 1, `last` = 1: `o_data <= acc + prod`, `o_valid <= 1`, `acc <= 0`.
  - When none of the above produces a result and the output is consumed or empty, `o_valid <= 0`.
- Arithmetic: all sums wrap modulo 2^ACC_W; there is no saturation.
- Flush:
  - Clears all entry-valid bits and sets `acc <= 0`. Buffer contents are not cleared.
  - A stationary write accepted in the same cycle is applied after the flush, so its entry ends valid.
  - Products already in the pipeline complete normally. Accumulating in-flight products add into the cleared accumulator.
  - Flush acts even while stalled; the accumulator clear takes priority over a same-cycle accumulate.
- Ordering: results leave in acceptance order, with no loss under backpressure.

## Timing
- A beat accepted at edge t produces `o_valid` = 1 after edge t+PIPE, provided no stall occurs in between. Each stall cycle adds one cycle.
- Throughput: one beat per cycle while `o_ready` = 1.
- `i_ready` is combinational from `o_valid` and `o_ready`; it has no combinational path from `i_valid`.
- `o_valid` and `o_data` are registered. While stalled they hold stable until the handshake completes.
- A stationary write at edge t is visible to a streaming beat accepted at edge t+1.
- `o_err` is set one edge after the offending acceptance and clears only on reset.

## Test plan
- Basic product: reset, write entry 2 = 3, then stream 7 with sel 2, `o_ready` = 1. Required: `o_data` = 21 with `o_valid` high for exactly 1 cycle, 2 cycles after acceptance.
- Signed extremes: entry 0 = 16'hFFFE, stream 16'h8000. Required: `o_data` = 36'h0_0001_0000 (+65536). Also stream 16'h8000 against entry 0 = 16'h8000: required `o_data` = 36'h0_4000_0000.
- Invalid entry: after reset, stream 5 with sel 1. Required: no `o_valid`, `o_err` = 1 from the next cycle onward. Then write entry 1 = 2 and stream 5: required `o_data` = 10 while `o_err` stays 1.
- Accumulate plus flush: entry 3 = 5, stream 1, 2, 3 back-to-back with `i_accum` = 1 and `i_last` on the third beat. Required: a single `o_valid` with `o_data` = 30. Then pulse `i_flush` and stream on sel 3: required `o_err` = 1.
- Backpressure: issue 4 back-to-back beats (entry 0 = 2, operands 1..4) and drop `o_ready` for 3 cycles once the first result appears. Required: `i_ready` = 0 throughout the stall, `o_data` held at 2, then results 2, 4, 6, 8 in order with none lost.
- Reset mid-run: assert `rst_n` = 0 asynchronously with 2 accumulating beats in flight. Required: `o_valid`, `o_data`, `o_err` = 0 immediately, and no output after release.

Source files
------------

// File: rtl/mult_switch_bank.sv
// Multiplier switch with a bank of selectable stationary operands, a PIPE-deep
// signed product pipeline, optional run accumulation and output backpressure.
module mult_switch_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int SEL_W  = 2,
    parameter int PIPE   = 2,
    parameter int GUARD  = 4
) (
    input  logic                              CLK,
    input  logic                              rst_n,
    input  logic                              i_valid,
    output logic                              i_ready,
    input  logic signed [DATA_W-1:0]          i_data,
    input  logic                              i_stationary,
    input  logic        [SEL_W-1:0]           i_sel,
    input  logic                              i_accum,
    input  logic                              i_last,
    input  logic                              i_flush,
    output logic                              o_valid,
    input  logic                              o_ready,
    output logic signed [2*DATA_W+GUARD-1:0]  o_data,
    output logic                              o_err
);

    localparam int ACC_W = 2*DATA_W + GUARD;

    logic signed [DATA_W-1:0]   r_buf [DEPTH];
    logic        [DEPTH-1:0]    r_ent_vld;
    logic                       r_err;

    logic        [PIPE-1:0]     r_vld_p;
    logic        [PIPE-1:0]     r_acc_p;
    logic        [PIPE-1:0]     r_last_p;
    logic signed [ACC_W-1:0]    r_prod_p [PIPE];

    logic signed [ACC_W-1:0]    r_acc;
    logic                       r_o_valid;
    logic signed [ACC_W-1:0]    r_o_data;

    logic                       w_stall;
    logic                       w_accept;
    logic                       w_wr;
    logic                       w_strm;
    logic                       w_hit;
    logic                       w_new_vld;
    logic signed [DATA_W-1:0]   w_op;
    logic signed [2*DATA_W-1:0] w_a;
    logic signed [2*DATA_W-1:0] w_b;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_acc_sum;

    assign w_stall   = r_o_valid & ~o_ready;
    assign i_ready   = ~w_stall;
    assign w_accept  = i_valid & ~w_stall;
    assign w_wr      = w_accept & i_stationary;
    assign w_strm    = w_accept & ~i_stationary;
    assign w_new_vld = w_strm & w_hit;

    // Out-of-range selects never match an entry, so they read as invalid.
    always_comb begin
        w_op  = '0;
        w_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (int'(i_sel) == k) begin
                w_op  = r_buf[k];
                w_hit = r_ent_vld[k];
            end
        end
    end

    assign w_a        = {{DATA_W{i_data[DATA_W-1]}}, i_data};
    assign w_b        = {{DATA_W{w_op[DATA_W-1]}}, w_op};
    assign w_prod     = w_a * w_b;
    assign w_prod_ext = {{GUARD{w_prod[2*DATA_W-1]}}, w_prod};

    // Flush clears first; a write in the same cycle lands on top and stays valid.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) r_buf[k] <= '0;
            r_ent_vld <= '0;
        end else begin
            if (i_flush) r_ent_vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                if (w_wr && int'(i_sel) == k) begin
                    r_buf[k]     <= i_data;
                    r_ent_vld[k] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)                r_err <= 1'b0;
        else if (w_strm && !w_hit) r_err <= 1'b1;
    end

    // Stage 0 .. PIPE-1: product pipeline, frozen as a whole while stalled
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p  <= '0;
            r_acc_p  <= '0;
            r_last_p <= '0;
        end else if (!w_stall) begin
            r_vld_p[0]  <= w_new_vld;
            r_acc_p[0]  <= i_accum;
            r_last_p[0] <= i_accum & i_last;
            for (int k = 1; k < PIPE; k++) begin
                r_vld_p[k]  <= r_vld_p[k-1];
                r_acc_p[k]  <= r_acc_p[k-1];
                r_last_p[k] <= r_last_p[k-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!w_stall) begin
            r_prod_p[0] <= w_prod_ext;
            for (int k = 1; k < PIPE; k++) r_prod_p[k] <= r_prod_p[k-1];
        end
    end

    assign w_acc_sum = r_acc + r_prod_p[PIPE-1];

    // Output stage: emit, accumulate or close a run; flush wins over accumulate
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
            r_acc     <= '0;
        end else begin
            if (!w_stall) begin
                r_o_valid <= 1'b0;
                if (r_vld_p[PIPE-1]) begin
                    if (!r_acc_p[PIPE-1]) begin
                        r_o_data  <= r_prod_p[PIPE-1];
                        r_o_valid <= 1'b1;
                    end else if (r_last_p[PIPE-1]) begin
                        r_o_data  <= w_acc_sum;
                        r_o_valid <= 1'b1;
                        r_acc     <= '0;
                    end else begin
                        r_acc <= w_acc_sum;
                    end
                end
            end
            if (i_flush) r_acc <= '0;
        end
    end

    assign o_valid = r_o_valid;
    assign o_data  = r_o_data;
    assign o_err   = r_err;

endmodule

// File: tb/tb_mult_switch_bank.sv
// Directed bench for mult_switch_bank: expected results are queued when a beat
// is driven and compared in order whenever the DUT hands a result downstream.
module tb_mult_switch_bank;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int SEL_W  = 2;
    localparam int PIPE   = 2;
    localparam int GUARD  = 4;
    localparam int ACC_W  = 2*DATA_W + GUARD;

    logic              CLK = 1'b0;
    logic              rst_n;
    logic              i_valid;
    logic              i_ready;
    logic [DATA_W-1:0] i_data;
    logic              i_stationary;
    logic [SEL_W-1:0]  i_sel;
    logic              i_accum;
    logic              i_last;
    logic              i_flush;
    logic              o_valid;
    logic              o_ready;
    logic [ACC_W-1:0]  o_data;
    logic              o_err;

    int n_assert = 0;
    int n_fail   = 0;
    logic [ACC_W-1:0] sb [$];

    mult_switch_bank #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .SEL_W(SEL_W), .PIPE(PIPE), .GUARD(GUARD)
    ) dut (
        .CLK(CLK), .rst_n(rst_n),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .i_stationary(i_stationary), .i_sel(i_sel), .i_accum(i_accum),
        .i_last(i_last), .i_flush(i_flush),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_err(o_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completed output handshake must match the queue head.
    always @(negedge CLK) begin
        if (rst_n && o_valid && o_ready) begin
            chk("out_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) chk("sb_data", 64'(o_data), 64'(sb.pop_front()));
        end
    end

    task automatic beat(input logic st, input logic [SEL_W-1:0] sel,
                        input logic [DATA_W-1:0] d, input logic acc, input logic last);
        int k;
        i_valid = 1'b1; i_stationary = st; i_sel = sel; i_data = d;
        i_accum = acc;  i_last = last;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!i_ready && k < 100);
        if (!i_ready) chk("accept_timeout", 64'(i_ready), 64'd1);
        @(posedge CLK);
        #1;
        i_valid = 1'b0; i_stationary = 1'b0; i_accum = 1'b0; i_last = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(negedge CLK);
            k++;
        end
        chk({"drain_", tag}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b1; i_valid = 1'b0; i_data = '0; i_stationary = 1'b0;
        i_sel = '0; i_accum = 1'b0; i_last = 1'b0; i_flush = 1'b0; o_ready = 1'b1;
        #2;
        do_reset();
        @(negedge CLK);
        chk("reset_i_ready", 64'(i_ready), 64'd1);
        chk("reset_o_valid", 64'(o_valid), 64'd0);
        chk("reset_o_data",  64'(o_data),  64'd0);
        chk("reset_o_err",   64'(o_err),   64'd0);

        // basic product with latency check
        beat(1'b1, 2'd2, 16'd3, 1'b0, 1'b0);
        sb.push_back(36'd21);
        beat(1'b0, 2'd2, 16'd7, 1'b0, 1'b0);
        @(negedge CLK); chk("lat_edge0", 64'(o_valid), 64'd0);
        @(negedge CLK); chk("lat_edge1", 64'(o_valid), 64'd0);
        @(negedge CLK); chk("lat_edge2", 64'(o_valid), 64'd1);
        chk("basic_data", 64'(o_data), 64'd21);
        @(negedge CLK); chk("lat_edge3", 64'(o_valid), 64'd0);

        // signed extremes; second write hits entry 0 while the first beat is in flight
        beat(1'b1, 2'd0, 16'hFFFE, 1'b0, 1'b0);
        sb.push_back(36'h0_0001_0000);
        beat(1'b0, 2'd0, 16'h8000, 1'b0, 1'b0);
        beat(1'b1, 2'd0, 16'h8000, 1'b0, 1'b0);
        sb.push_back(36'h0_4000_0000);
        beat(1'b0, 2'd0, 16'h8000, 1'b0, 1'b0);
        drain("signed");

        // invalid entry
        do_reset();
        beat(1'b0, 2'd1, 16'd5, 1'b0, 1'b0);
        @(negedge CLK); chk("err_set", 64'(o_err), 64'd1);
        beat(1'b1, 2'd1, 16'd2, 1'b0, 1'b0);
        sb.push_back(36'd10);
        beat(1'b0, 2'd1, 16'd5, 1'b0, 1'b0);
        drain("invalid");
        chk("err_sticky", 64'(o_err), 64'd1);

        // accumulation run, then flush
        do_reset();
        @(negedge CLK); chk("err_cleared", 64'(o_err), 64'd0);
        beat(1'b1, 2'd3, 16'd5, 1'b0, 1'b0);
        sb.push_back(36'd30);
        beat(1'b0, 2'd3, 16'd1, 1'b1, 1'b0);
        beat(1'b0, 2'd3, 16'd2, 1'b1, 1'b0);
        beat(1'b0, 2'd3, 16'd3, 1'b1, 1'b1);
        drain("accum");
        repeat (3) @(negedge CLK);
        chk("accum_no_err", 64'(o_err), 64'd0);
        i_flush = 1'b1;
        @(posedge CLK);
        #1;
        i_flush = 1'b0;
        beat(1'b0, 2'd3, 16'd4, 1'b0, 1'b0);
        @(negedge CLK); chk("flush_err", 64'(o_err), 64'd1);
        // write in the flush cycle survives the flush
        i_flush = 1'b1;
        beat(1'b1, 2'd2, 16'd9, 1'b0, 1'b0);
        i_flush = 1'b0;
        sb.push_back(36'd27);
        beat(1'b0, 2'd2, 16'd3, 1'b0, 1'b0);
        drain("flush_write");

        // backpressure
        do_reset();
        beat(1'b1, 2'd0, 16'd2, 1'b0, 1'b0);
        sb.push_back(36'd2); sb.push_back(36'd4); sb.push_back(36'd6); sb.push_back(36'd8);
        fork
            begin
                for (int i = 1; i <= 4; i++) beat(1'b0, 2'd0, 16'(i), 1'b0, 1'b0);
            end
            begin : bp_stall
                int k;
                k = 0;
                do begin
                    @(posedge CLK);
                    #1;
                    k++;
                end while (!o_valid && k < 50);
                chk("bp_first_seen", 64'(o_valid), 64'd1);
                o_ready = 1'b0;
                repeat (3) begin
                    @(negedge CLK);
                    chk("bp_i_ready", 64'(i_ready), 64'd0);
                    chk("bp_hold_valid", 64'(o_valid), 64'd1);
                    chk("bp_hold_data", 64'(o_data), 64'd2);
                end
                @(posedge CLK);
                #1;
                o_ready = 1'b1;
            end
        join
        drain("backpressure");

        // reset in the middle of an accumulation run
        beat(1'b1, 2'd0, 16'd3, 1'b0, 1'b0);
        beat(1'b0, 2'd2, 16'd1, 1'b0, 1'b0);
        beat(1'b0, 2'd0, 16'd1, 1'b1, 1'b0);
        beat(1'b0, 2'd0, 16'd2, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", 64'(o_valid), 64'd0);
        chk("midrst_o_data",  64'(o_data),  64'd0);
        chk("midrst_o_err",   64'(o_err),   64'd0);
        chk("midrst_i_ready", 64'(i_ready), 64'd1);
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge CLK);
            if (o_valid) seen++;
        end
        chk("midrst_no_output", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
